// File: rtl/mc_core_pkg.sv
// rtl/mc_core_pkg.sv - shared constants, types and decode helpers for mc_core
//
// Contents: RV32I-subset opcode/funct constants, FSM state enum, ALU-op enum,
// legality check, ALU-op decode and immediate generation.
// Optional feature macro: MC_CORE_MUL_EN (consumed by mc_core and mc_core_alu;
// the helpers here take the enable as an argument).
package mc_core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_MUL
  } alu_op_e;

  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic mul_en);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_R: begin
        // Base R-type: every funct3 except SLTU is in the subset.
        if (f7 == F7_BASE)     ok = (f3 != F3_SLTU);
        else if (f7 == F7_SUB) ok = (f3 == F3_ADD);
        else if (f7 == F7_MUL) ok = mul_en && (f3 == F3_ADD);
        else                   ok = 1'b0;
      end
      OP_I:              ok = (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
                              (f3 == F3_OR)  || (f3 == F3_AND);
      OP_LOAD, OP_STORE: ok = (f3 == F3_WORD);
      OP_BRANCH:         ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
      OP_JAL:            ok = 1'b1;
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_e alu_op_of(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic [6:0] f7);
    alu_op_e op;
    op = ALU_ADD;
    if (opcode == OP_R || opcode == OP_I) begin
      case (f3)
        F3_ADD:  op = (opcode == OP_R && f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        F3_SLL:  op = ALU_SLL;
        F3_SLT:  op = ALU_SLT;
        F3_XOR:  op = ALU_XOR;
        F3_SRL:  op = ALU_SRL;
        F3_OR:   op = ALU_OR;
        F3_AND:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
      if (opcode == OP_R && f7 == F7_MUL) op = ALU_MUL;
    end else if (opcode == OP_BRANCH) begin
      // Branches compare via subtraction and the zero flag.
      op = ALU_SUB;
    end
    return op;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    logic [31:0] imm;
    case (i[6:0])
      OP_STORE:  imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_JAL:    imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:   imm = {{20{i[31]}}, i[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_core_alu.sv
// rtl/mc_core_alu.sv - combinational ALU for mc_core
//
// Ports: op (alu_op_e), a/b (32-bit operands) -> result (32-bit), zero (result == 0).
// Optional feature macro: MC_CORE_MUL_EN adds the low-32-bit multiply path.
module mc_core_alu import mc_core_pkg::*; (
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
`ifdef MC_CORE_MUL_EN
      ALU_MUL: result = a * b;
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle RV32I-subset core over one shared memory port
//
// Parameters: ADDR_WIDTH (byte address width, 4..32), RESET_PC (word-aligned).
// Ports: clk, reset (async, active-low);
//        memory: mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready;
//        observation: pc_out, instr, state_out, retire, halted.
// Optional feature macro: MC_CORE_MUL_EN makes R-type MUL legal.
module mc_core import mc_core_pkg::*; #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [31:0]           instr,
  output logic [2:0]            state_out,
  output logic                  retire,
  output logic                  halted
);

`ifdef MC_CORE_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_e                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           instr_q;
  logic [31:0]           op_a, op_b, imm_q, wb_data;
  logic [31:0]           rf [32];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign f3     = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign f7     = instr_q[31:25];

  logic is_r, is_branch, is_jal, is_load, is_store;
  assign is_r      = (opcode == OP_R);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_result;
  logic        alu_zero;
  assign alu_op = alu_op_of(opcode, f3, f7);
  assign alu_b  = (is_r || is_branch) ? op_b : imm_q;

  mc_core_alu u_alu (
    .op     (alu_op),
    .a      (op_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  logic [ADDR_WIDTH-1:0] pc_plus4, target, ls_addr;
  logic                  taken, ctl_misaligned, ls_misaligned;
  assign pc_plus4       = pc + ADDR_WIDTH'(4);
  assign target         = pc + ADDR_WIDTH'(imm_q);
  assign ls_addr        = ADDR_WIDTH'(alu_result);
  assign taken          = is_jal || (is_branch && ((f3 == F3_BEQ) ? alu_zero : !alu_zero));
  // A misaligned target only matters when control actually transfers there.
  assign ctl_misaligned = taken && (target[1:0] != 2'b00);
  assign ls_misaligned  = (ls_addr[1:0] != 2'b00);

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXECUTE: retire = (is_branch || is_jal) && !ctl_misaligned;
      S_MEM:     retire = is_store && mem_ready;
      S_WB:      retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wdata;
  assign rf_we    = (state == S_WB) || (state == S_EXECUTE && is_jal && !ctl_misaligned);
  assign rf_wdata = (state == S_WB) ? wb_data : 32'(pc_plus4);

  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0) rf[rd] <= rf_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      instr_q   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      imm_q     <= '0;
      wb_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // mem_req is low here only in the first cycle after reset.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ready) begin
            instr_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!is_legal(opcode, f3, f7, MUL_EN)) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            op_a  <= rs1_val;
            op_b  <= rs2_val;
            imm_q <= imm_gen(instr_q);
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_branch || is_jal) begin
            if (ctl_misaligned) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc       <= taken ? target : pc_plus4;
              mem_addr <= taken ? target : pc_plus4;
              mem_req  <= 1'b1;
              state    <= S_FETCH;
            end
          end else if (is_load || is_store) begin
            if (ls_misaligned) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= is_store;
              mem_addr <= ls_addr;
              if (is_store) mem_wdata <= op_b;
              state    <= S_MEM;
            end
          end else begin
            wb_data <= alu_result;
            state   <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (is_store) begin
              // Store completes; the next fetch request follows back-to-back.
              pc       <= pc_plus4;
              mem_addr <= pc_plus4;
              state    <= S_FETCH;
            end else begin
              wb_data <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          pc       <= pc_plus4;
          mem_addr <= pc_plus4;
          mem_req  <= 1'b1;
          state    <= S_FETCH;
        end
        default: begin
          // S_HALT: everything frozen until reset.
        end
      endcase
    end
  end

  assign pc_out    = pc;
  assign instr     = instr_q;
  assign state_out = state;

endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - directed table-driven bench for mc_core
module tb_mc_core;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req, mem_we, mem_ready, retire, halted;
  logic [AW-1:0] mem_addr, pc_out;
  logic [31:0]   mem_wdata, mem_rdata, instr;
  logic [2:0]    state_out;

  logic [31:0] prog [256];
  logic [31:0] dmem [16];
  int          wait_cycles = 0;
  int          wait_cnt = 0;
  int          st_count = 0;
  logic [31:0] st_addr = '0, st_data = '0;
  int          checks = 0, errors = 0;

  mc_core #(.ADDR_WIDTH(AW), .RESET_PC(10'h040)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .instr(instr), .state_out(state_out), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  // Bytes 0x00-0x3F are data, everything above is program.
  assign mem_rdata = (mem_addr[9:6] == 4'd0) ? dmem[mem_addr[5:2]] : prog[mem_addr[9:2]];
  assign mem_ready = (wait_cycles == 0) || (mem_req && wait_cnt >= wait_cycles);

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (reset && mem_req && mem_we && mem_ready) begin
      dmem[mem_addr[5:2]] <= mem_wdata;
      st_count <= st_count + 1;
      st_addr  <= 32'(mem_addr);
      st_data  <= mem_wdata;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          waits;
    int          cycles;
    int          st;
    logic [31:0] sa;
    logic [31:0] sd;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] ins, int waits, int cycles,
                              int st, logic [31:0] sa, logic [31:0] sd);
    vec_t v;
    v.pc = pc; v.ins = ins; v.waits = waits; v.cycles = cycles;
    v.st = st; v.sa = sa; v.sd = sd;
    return v;
  endfunction

  function automatic logic [31:0] r_ins(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_ins(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] s_ins(int imm, int rs2, int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_ins(int imm, int rs2, int rs1, logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_ins(int imm, int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, st0;
    logic pw;
    logic [63:0] bus;
    string nm;
    nm = $sformatf("vec%0d@%0h", idx, v.pc);
    wait_cycles = v.waits;
    st0 = st_count;
    @(negedge clk);
    n = 1;
    chk({nm, " fetch_addr"}, 64'(mem_addr), 64'(v.pc));
    chk({nm, " fetch_req"}, 64'(mem_req), 64'd1);
    chk({nm, " pc_out"}, 64'(pc_out), 64'(v.pc));
    while (!retire && !halted && n < 200) begin
      pw  = mem_req && !mem_ready;
      bus = {mem_req, mem_we, 20'(mem_addr), mem_wdata};
      @(negedge clk);
      n++;
      if (pw) chk({nm, " wait_stable"}, {mem_req, mem_we, 20'(mem_addr), mem_wdata}, bus);
    end
    chk({nm, " cycles"}, 64'(n), 64'(v.cycles));
    chk({nm, " retire"}, 64'(retire), 64'd1);
    @(posedge clk);
    #1;
    chk({nm, " stores"}, 64'(st_count - st0), 64'(v.st));
    if (v.st != 0) begin
      chk({nm, " st_addr"}, 64'(st_addr), 64'(v.sa));
      chk({nm, " st_data"}, 64'(st_data), 64'(v.sd));
    end
  endtask

  task automatic run_halt(input string nm, input logic [31:0] pc, input int cycles);
    int n, st0;
    logic saw_ret, saw_req;
    wait_cycles = 0;
    st0 = st_count;
    saw_ret = 1'b0;
    saw_req = 1'b0;
    @(negedge clk);
    n = 1;
    chk({nm, " fetch_addr"}, 64'(mem_addr), 64'(pc));
    while (!halted && n < 50) begin
      saw_ret |= retire;
      @(negedge clk);
      n++;
    end
    chk({nm, " halted"}, 64'(halted), 64'd1);
    chk({nm, " cycles"}, 64'(n), 64'(cycles));
    repeat (8) begin
      @(negedge clk);
      saw_ret |= retire;
      saw_req |= mem_req;
    end
    chk({nm, " no_retire"}, 64'(saw_ret), 64'd0);
    chk({nm, " no_req"}, 64'(saw_req), 64'd0);
    chk({nm, " pc_frozen"}, 64'(pc_out), 64'(pc));
    chk({nm, " state"}, 64'(state_out), 64'd5);
    chk({nm, " no_store"}, 64'(st_count - st0), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;

    vecs.push_back(mk(32'h40, i_ins(5, 0, 3'b000, 1, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h44, i_ins(7, 0, 3'b000, 2, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h48, r_ins(7'h00, 2, 1, 3'b000, 3), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h4C, s_ins(0, 3, 0), 0, 4, 1, 32'h0, 32'd12));
    vecs.push_back(mk(32'h50, i_ins(0, 0, 3'b010, 4, OPL), 3, 11, 0, 0, 0));
    vecs.push_back(mk(32'h54, s_ins(4, 4, 0), 0, 4, 1, 32'h4, 32'd12));
    vecs.push_back(mk(32'h58, b_ins(8, 2, 1, 3'b000), 2, 5, 0, 0, 0));
    vecs.push_back(mk(32'h5C, j_ins(12, 6), 0, 3, 0, 0, 0));
    vecs.push_back(mk(32'h68, b_ins(-8, 2, 1, 3'b001), 0, 3, 0, 0, 0));
    vecs.push_back(mk(32'h60, s_ins(8, 6, 0), 0, 4, 1, 32'h8, 32'h60));
    vecs.push_back(mk(32'h64, j_ins(12, 0), 0, 3, 0, 0, 0));
    vecs.push_back(mk(32'h70, r_ins(7'h20, 2, 1, 3'b000, 9), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h74, r_ins(7'h00, 1, 9, 3'b010, 10), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h78, r_ins(7'h00, 2, 1, 3'b001, 11), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h7C, r_ins(7'h00, 2, 9, 3'b101, 12), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h80, i_ins(-1, 9, 3'b100, 13, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h84, i_ins(-3, 9, 3'b010, 14, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h88, i_ins(12'h0F0, 9, 3'b111, 15, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h8C, r_ins(7'h00, 15, 13, 3'b110, 16), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h90, r_ins(7'h00, 2, 16, 3'b111, 17), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h94, r_ins(7'h00, 1, 16, 3'b100, 18), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h98, i_ins(12'h300, 18, 3'b110, 19, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'h9C, s_ins(16, 10, 0), 0, 4, 1, 32'h10, 32'd1));
    vecs.push_back(mk(32'hA0, s_ins(20, 11, 0), 0, 4, 1, 32'h14, 32'h280));
    vecs.push_back(mk(32'hA4, s_ins(24, 12, 0), 0, 4, 1, 32'h18, 32'h01FF_FFFF));
    vecs.push_back(mk(32'hA8, s_ins(28, 14, 0), 0, 4, 1, 32'h1C, 32'd0));
    vecs.push_back(mk(32'hAC, s_ins(32, 19, 0), 0, 4, 1, 32'h20, 32'h3F4));
    vecs.push_back(mk(32'hB0, s_ins(36, 17, 0), 0, 4, 1, 32'h24, 32'd1));
    vecs.push_back(mk(32'hB4, i_ins(9, 0, 3'b000, 0, OPI), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'hB8, s_ins(40, 0, 0), 0, 4, 1, 32'h28, 32'd0));
`ifdef MC_CORE_MUL_EN
    vecs.push_back(mk(32'hBC, r_ins(7'h01, 2, 1, 3'b000, 5), 0, 4, 0, 0, 0));
    vecs.push_back(mk(32'hC0, s_ins(44, 5, 0), 0, 4, 1, 32'h2C, 32'd35));
`else
    prog[32'hBC >> 2] = r_ins(7'h01, 2, 1, 3'b000, 5);
`endif
    foreach (vecs[i]) prog[vecs[i].pc[9:2]] = vecs[i].ins;

    // Reset state, with mem_ready high to show it is ignored.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'h40);
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst pc_out", 64'(pc_out), 64'h40);
    chk("rst instr", 64'(instr), 64'd0);
    chk("rst state", 64'(state_out), 64'd0);
    chk("rst retire", 64'(retire), 64'd0);
    chk("rst halted", 64'(halted), 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);
`ifndef MC_CORE_MUL_EN
    run_halt("mul_illegal", 32'hBC, 3);
`endif

    // Misaligned load: ADDI x1,x0,2 then LW x2,4(x1) -> address 6.
    reset = 1'b0;
    prog[16] = i_ins(2, 0, 3'b000, 1, OPI);
    prog[17] = i_ins(4, 1, 3'b010, 2, OPL);
    @(negedge clk);
    chk("rst2 halted", 64'(halted), 64'd0);
    reset = 1'b1;
    run_vec(mk(32'h40, prog[16], 0, 4, 0, 0, 0), 100);
    run_halt("lw_misaligned", 32'h44, 4);

    // Misaligned JAL target 0x42.
    reset = 1'b0;
    prog[16] = j_ins(2, 1);
    @(negedge clk);
    reset = 1'b1;
    run_halt("jal_misaligned", 32'h40, 4);

    // Reset in the middle of a waiting fetch aborts the request at once.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_cycles = 5;
    repeat (2) @(negedge clk);
    chk("abort pre_req", 64'(mem_req), 64'd1);
    chk("abort pre_addr", 64'(mem_addr), 64'h40);
    reset = 1'b0;
    #1;
    chk("abort mem_req", 64'(mem_req), 64'd0);
    chk("abort state", 64'(state_out), 64'd0);
    chk("abort halted", 64'(halted), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
